// File: rtl/stream_mux.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux
//  Purpose  : NUM_CH valid/ready input channels merged onto one registered
//             output stream. Selection is either fixed (sel) or round-robin.
//             Optional packet lock is enabled by defining STREAM_MUX_LAST_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
`ifdef STREAM_MUX_LAST_EN
    input  logic [NUM_CH-1:0]       in_last,
    output logic                    out_last,
`endif
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_ch
);

    localparam logic [SEL_W:0]   C_NUM_CH  = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] C_LAST_CH = SEL_W'(NUM_CH - 1);

    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_data_q,  out_data_d;
    logic [SEL_W-1:0]    out_ch_q,    out_ch_d;
    logic [SEL_W-1:0]    ptr_q,       ptr_d;
`ifdef STREAM_MUX_LAST_EN
    logic                out_last_q,  out_last_d;
    logic                lock_q,      lock_d;
    logic [SEL_W-1:0]    lock_ch_q,   lock_ch_d;
`endif

    logic                w_load_en;
    logic [NUM_CH-1:0]   w_rot;
    logic                w_rr_found;
    logic [SEL_W-1:0]    w_rr_idx;
    logic                w_grant_any;
    logic [SEL_W-1:0]    w_grant_idx;
    logic [NUM_CH-1:0]   w_grant;
    logic [WIDTH-1:0]    w_sel_data;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic                w_xfer;

    assign w_load_en = !out_valid_q || out_ready;

    // Rotate valids so that bit 0 is the pointer channel; first set bit wins.
    always_comb begin : rr_search
        int idx;
        w_rot      = NUM_CH'({in_valid, in_valid} >> ptr_q);
        w_rr_found = 1'b0;
        idx        = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_rr_found && w_rot[k]) begin
                w_rr_found = 1'b1;
                idx        = int'(ptr_q) + k;
            end
        end
        if (idx >= NUM_CH) begin
            idx = idx - NUM_CH;
        end
        w_rr_idx = SEL_W'(idx);
    end

    always_comb begin : grant_select
        w_grant_any = 1'b0;
        w_grant_idx = '0;
`ifdef STREAM_MUX_LAST_EN
        if (lock_q) begin
            w_grant_any = 1'b1;
            w_grant_idx = lock_ch_q;
        end else
`endif
        if (mode) begin
            w_grant_any = w_rr_found;
            w_grant_idx = w_rr_idx;
        end else begin
            w_grant_any = ({1'b0, sel} < C_NUM_CH);
            w_grant_idx = sel;
        end
    end

    always_comb begin : channel_mux
        w_grant     = '0;
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            w_grant[i] = w_grant_any && (w_grant_idx == SEL_W'(i));
            if (w_grant[i]) begin
                w_sel_data  = in_data[i*WIDTH +: WIDTH];
                w_sel_valid = in_valid[i];
`ifdef STREAM_MUX_LAST_EN
                w_sel_last  = in_last[i];
`endif
            end
        end
    end

    assign w_xfer   = w_sel_valid && w_load_en;
    assign in_ready = w_grant & {NUM_CH{w_load_en && !reset}};

    always_comb begin : next_state
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
`ifdef STREAM_MUX_LAST_EN
        out_last_d  = out_last_q;
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
`endif
        if (w_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = w_sel_data;
            out_ch_d    = w_grant_idx;
            // Pointer only moves at a packet boundary (every beat without the lock feature).
            if (mode && w_sel_last) begin
                ptr_d = (w_grant_idx == C_LAST_CH) ? '0 : w_grant_idx + 1'b1;
            end
`ifdef STREAM_MUX_LAST_EN
            out_last_d = w_sel_last;
            lock_d     = !w_sel_last;
            lock_ch_d  = w_grant_idx;
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
`ifdef STREAM_MUX_LAST_EN
            out_last_q  <= 1'b0;
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
`ifdef STREAM_MUX_LAST_EN
            out_last_q  <= out_last_d;
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
`ifdef STREAM_MUX_LAST_EN
    assign out_last  = out_last_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_mux
//  Purpose  : Self-checking bench for stream_mux (NUM_CH=4, SEL_W=3) with a
//             transaction-level reference model; honours STREAM_MUX_LAST_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_mux;

    localparam int WIDTH  = 32;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 3;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [SEL_W-1:0]        out_ch;
`ifdef STREAM_MUX_LAST_EN
    logic [NUM_CH-1:0]       in_last;
    logic                    out_last;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int               m_ptr;
    bit               m_valid;
    logic [WIDTH-1:0] m_data;
    int               m_ch;
    bit               m_last;
    bit               m_lock;
    int               m_lock_ch;

    stream_mux #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
`ifdef STREAM_MUX_LAST_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic int model_grant();
        if (m_lock) return m_lock_ch;
        if (mode == 1'b0) return (int'(sel) < NUM_CH) ? int'(sel) : -1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (in_valid[(m_ptr + k) % NUM_CH]) return (m_ptr + k) % NUM_CH;
        end
        return -1;
    endfunction

    function automatic logic [NUM_CH-1:0] model_ready();
        int g;
        g = model_grant();
        if (reset || g < 0 || !(!m_valid || out_ready)) return '0;
        return NUM_CH'(1) << g;
    endfunction

    // Advance one clock; model is updated from the inputs present before the edge.
    task automatic cycle();
        int g;
        bit xfer;
        bit lst;
        bit md;
        logic [WIDTH-1:0] d;
        g    = model_grant();
        xfer = (g >= 0) && (!m_valid || out_ready) && in_valid[g];
        md   = mode;
        lst  = 1'b1;
        d    = '0;
        if (g >= 0) begin
            d = in_data[g*WIDTH +: WIDTH];
`ifdef STREAM_MUX_LAST_EN
            lst = in_last[g];
`endif
        end
        @(posedge clk);
        #1;
        if (reset) begin
            m_valid = 0; m_data = '0; m_ch = 0; m_ptr = 0;
            m_last = 0; m_lock = 0; m_lock_ch = 0;
        end else if (xfer) begin
            m_valid = 1; m_data = d; m_ch = g; m_last = lst;
            if (md && lst) m_ptr = (g + 1) % NUM_CH;
`ifdef STREAM_MUX_LAST_EN
            m_lock = !lst; m_lock_ch = g;
`endif
        end else if (out_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic set_patterned_data();
        for (int i = 0; i < NUM_CH; i++) in_data[i*WIDTH +: WIDTH] = 32'hA5A5_0000 | 32'(i);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; mode = 1'b1; in_valid = '1; out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_tests++;
            if (in_ready !== '0) begin
                n_fail++; $display("FAIL reset_in_ready: got %b, required 0000", in_ready);
            end
            cycle();
        end
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b data=%h ch=%0d, required 0/0/0", out_valid, out_data, out_ch);
        end
        reset = 1'b0;
    endtask

    task automatic test_fixed();
        mode = 1'b0; sel = 3'd2; in_valid = '1; out_ready = 1'b1;
        set_patterned_data();
        #1;
        n_tests++;
        if (in_ready !== 4'b0100) begin
            n_fail++; $display("FAIL fixed_in_ready: got %b, required 0100", in_ready);
        end
        cycle();
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0002 || out_ch !== 3'd2) begin
            n_fail++;
            $display("FAIL fixed_output: got valid=%b data=%h ch=%0d, required 1/a5a50002/2", out_valid, out_data, out_ch);
        end
        sel = 3'd5;
        #1;
        n_tests++;
        if (in_ready !== '0) begin
            n_fail++; $display("FAIL fixed_sel_oob_ready: got %b, required 0000", in_ready);
        end
        cycle();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL fixed_sel_oob_valid: got %b, required 0", out_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        mode = 1'b1; in_valid = '1; out_ready = 1'b1;
        set_patterned_data();
        for (int k = 0; k < 6; k++) begin
            cycle();
            n_tests++;
            if (out_valid !== 1'b1 || out_ch !== SEL_W'(k % 4) || out_data !== (32'hA5A5_0000 | 32'(k % 4))) begin
                n_fail++;
                $display("FAIL rr_all beat %0d: got valid=%b ch=%0d data=%h, required ch=%0d", k, out_valid, out_ch, out_data, k % 4);
            end
        end
        do_reset();
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            cycle();
            n_tests++;
            if (out_valid !== 1'b1 || out_ch !== ((k % 2 == 0) ? 3'd1 : 3'd3)) begin
                n_fail++;
                $display("FAIL rr_sparse beat %0d: got valid=%b ch=%0d, required ch=%0d", k, out_valid, out_ch, (k % 2 == 0) ? 1 : 3);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        mode = 1'b1; in_valid = '1; out_ready = 1'b1;
        set_patterned_data();
        cycle();
        cycle();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++;
            if (in_ready !== '0) begin
                n_fail++; $display("FAIL bp_in_ready cycle %0d: got %b, required 0000", c, in_ready);
            end
            cycle();
            n_tests++;
            if (out_valid !== 1'b1 || out_ch !== 3'd1 || out_data !== 32'hA5A5_0001) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: got valid=%b ch=%0d data=%h, required 1/1/a5a50001", c, out_valid, out_ch, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 4'b0100) begin
            n_fail++; $display("FAIL bp_release_ready: got %b, required 0100", in_ready);
        end
        cycle();
        n_tests++;
        if (out_ch !== 3'd2) begin
            n_fail++; $display("FAIL bp_release_ch: got %0d, required 2", out_ch);
        end
    endtask

    task automatic test_reset_mid();
        mode = 1'b1; in_valid = '1; out_ready = 1'b0;
        cycle();
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_setup_valid: got %b, required 1", out_valid);
        end
        reset = 1'b1;
        cycle();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_valid: got %b, required 0", out_valid);
        end
        reset = 1'b0; out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 4'b0001) begin
            n_fail++; $display("FAIL mid_first_grant: got %b, required 0001", in_ready);
        end
        cycle();
        n_tests++;
        if (out_ch !== 3'd0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_first_ch: got ch=%0d valid=%b, required 0/1", out_ch, out_valid);
        end
    endtask

`ifdef STREAM_MUX_LAST_EN
    task automatic test_packet_lock();
        do_reset();
        mode = 1'b1; sel = 3'd1; in_valid = 4'b0011; out_ready = 1'b1;
        set_patterned_data();
        for (int k = 0; k < 4; k++) begin
            in_last = {2'b00, 1'b1, (k == 2)};
            mode    = (k == 1) ? 1'b0 : 1'b1;
            cycle();
            n_tests++;
            if (out_ch !== ((k < 3) ? 3'd0 : 3'd1) || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL pkt_ch beat %0d: got ch=%0d valid=%b, required %0d", k, out_ch, out_valid, (k < 3) ? 0 : 1);
            end
            if (k < 3) begin
                n_tests++;
                if (out_last !== (k == 2)) begin
                    n_fail++; $display("FAIL pkt_last beat %0d: got %b, required %0d", k, out_last, (k == 2));
                end
            end
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(0, 59) == 0);
            mode      = ($urandom_range(0, 3) != 0);
            sel       = SEL_W'($urandom_range(0, 5));
            in_valid  = NUM_CH'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_CH; i++) in_data[i*WIDTH +: WIDTH] = $urandom;
`ifdef STREAM_MUX_LAST_EN
            in_last   = NUM_CH'($urandom);
`endif
            #1;
            n_tests++;
            if (in_ready !== model_ready()) begin
                n_fail++; $display("FAIL rand_in_ready cycle %0d: got %b, required %b", c, in_ready, model_ready());
            end
            cycle();
            n_tests++;
            if (out_valid !== m_valid || out_data !== m_data || out_ch !== SEL_W'(m_ch)) begin
                n_fail++;
                $display("FAIL rand_output cycle %0d: got v=%b d=%h ch=%0d, required v=%b d=%h ch=%0d",
                         c, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
            end
`ifdef STREAM_MUX_LAST_EN
            n_tests++;
            if (out_last !== m_last) begin
                n_fail++; $display("FAIL rand_out_last cycle %0d: got %b, required %b", c, out_last, m_last);
            end
`endif
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; out_ready = 1'b0;
`ifdef STREAM_MUX_LAST_EN
        in_last = '0;
`endif
        m_ptr = 0; m_valid = 0; m_data = '0; m_ch = 0; m_last = 0; m_lock = 0; m_lock_ch = 0;
        #1;
        test_reset();
        test_fixed();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
`ifdef STREAM_MUX_LAST_EN
        test_packet_lock();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
